ahb_burst_sequencer: RTL and testbench
======================================

// Module: ahb_burst_sequencer
// PURPOSE
//  Parametrised AHB-Lite burst master sequencer. Replaces the single-beat
//  instruction-driven stimulus path feeding the AHB master/slave top.
//  Accepts one command (start addr, HBURST type, length, direction, data seed),
//  issues the pipelined address/data phases with HREADY stalls and HRESP
//  abort, and returns read beats plus a completion pulse.
// PARAMETERS
//  DW     8   data width in bits; legal values 8, 16, 32; beat size = DW/8 bytes
//  AW     11  address width in bits; must be >= 10
//  LEN_W  4   width of cmd_len (INCR beats-1; max 2^LEN_W beats)
// PORTS
//  hclk        in   1      clock, all logic on rising edge
//  resetn      in   1      asynchronous active-low reset
//  cmd_valid   in   1      command request
//  cmd_ready   out  1      sequencer idle; command accepted when valid&&ready
//  cmd_addr    in   AW     start byte address; low log2(DW/8) bits forced to 0
//  cmd_burst   in   3      AHB HBURST: 0 SINGLE,1 INCR,2 WRAP4,3 INCR4,4 WRAP8,5 INCR8,6 WRAP16,7 INCR16
//  cmd_len     in   LEN_W  beats-1; used only when cmd_burst==INCR
//  cmd_write   in   1      1 write, 0 read
//  cmd_wdata   in   DW     write seed; beat i writes cmd_wdata+i (mod 2^DW)
//  haddr       out  AW     AHB address
//  htrans      out  2      0 IDLE, 2 NONSEQ, 3 SEQ (BUSY never issued)
//  hwrite      out  1      AHB direction
//  hburst      out  3      AHB burst type, copy of cmd_burst
//  hsize       out  3      log2(DW/8), constant
//  hwdata      out  DW     write data, data phase
//  hrdata      in   DW     read data
//  hready      in   1      transfer complete / stall when 0
//  hresp       in   1      1 = ERROR
//  rd_data     out  DW     captured read beat
//  rd_valid    out  1      1-cycle pulse per read beat
//  done        out  1      1-cycle pulse at burst end (normal or aborted)
//  err         out  1      1-cycle pulse with done when burst aborted by hresp
// BEHAVIOUR
//  - Reset: htrans=0, haddr=0, hwrite=0, hburst=0, hwdata=0, cmd_ready=1,
//    rd_data=0, rd_valid=0, done=0, err=0; state IDLE. Reset mid-burst aborts
//    at once; command lost, no done.
//  - FSM: IDLE -> ADDR (on accept) -> ADDR while beats remain -> DRAIN -> IDLE.
//    ADDR->IDLE on hresp. cmd_ready=1 only in IDLE; cmd_valid ignored otherwise.
//  - Beats N: SINGLE 1, INCR cmd_len+1, WRAP/INCR4 4, 8, 16.
//  - Cycle after accept: beat 0 address phase, htrans=NONSEQ. Later beats SEQ.
//  - Address/control held while hready=0. hready=1 in an address phase moves
//    that beat to data phase and presents next beat (or htrans=IDLE after
//    last, state DRAIN).
//  - hwdata for beat i driven in its data phase, held until hready=1.
//    Reads: hrdata captured on hready=1 in data phase; rd_valid next cycle.
//  - INCR addr_i = start + i*DW/8 mod 2^AW. WRAPn: mask = n*DW/8-1,
//    addr_i = (start & ~mask) | ((start + i*DW/8) & mask).
//  - INCR/INCRn beat whose addr[9:0]==0 (1KB crossing, i>0) issued as NONSEQ.
//  - DRAIN: last data phase completes on hready=1; done pulses next cycle;
//    cmd_ready=1 that same cycle (done and new accept may coincide).
//  - hresp=1 with hready=0 (1st error cycle): htrans=IDLE from next edge,
//    remaining beats dropped; done+err pulse after 2nd error cycle
//    (hresp=1, hready=1). No rd_valid for errored beat.
//  - Latency: accept to first NONSEQ = 1 cycle. Zero-wait N-beat burst:
//    done at accept+N+2.
// CONFIGURATION
//  WRAP_BURST_EN defined: WRAP4/8/16 generate wrapping addresses as above.
//  Not defined: wrap encodings executed as INCR of same length; hburst
//  still reports the received code.
// TESTING
//  1 write INCR4 addr=0x010 seed=0x40, hready=1 -> haddr 10,11,12,13;
//    htrans 2,3,3,3; hwdata 40,41,42,43; done at accept+6
//  2 read WRAP4 addr=0x00E (DW=8, WRAP_BURST_EN) -> haddr 0E,0F,0C,0D;
//    4 rd_valid with hrdata values
//  3 read SINGLE addr=0x005, hready low 3 cycles in data phase -> haddr held;
//    one rd_valid; done 1 cycle after hready rises
//  4 write INCR cmd_len=3 addr=0x3FE -> haddr 3FE,3FF,400,401;
//    htrans 2,3,2,3
//  5 INCR8 write, hresp error on beat 2 -> htrans IDLE after 1st error cycle;
//    done=err=1 once; cmd_ready back
//  6 resetn low mid INCR16 -> all outputs reset immediately;
//    new command after release runs normally

Source files
------------

// File: rtl/ahb_burst_sequencer.sv
// AHB-Lite burst master sequencer: one command in, pipelined address/data phases out.
// Define WRAP_BURST_EN to generate wrapping addresses for WRAP4/8/16; otherwise they run as INCR.
//
// state   | meaning
// S_IDLE  | waiting for a command, cmd_ready high
// S_ADDR  | a beat is in address phase (previous beat possibly in data phase)
// S_DRAIN | all addresses issued, last data phase outstanding
// S_ERR   | first ERROR cycle seen, waiting for second (hready high) cycle
module ahb_burst_sequencer #(
    parameter int DW    = 8,
    parameter int AW    = 11,
    parameter int LEN_W = 4
) (
    input  logic             hclk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [2:0]       cmd_burst,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_write,
    input  logic [DW-1:0]    cmd_wdata,
    output logic [AW-1:0]    haddr,
    output logic [1:0]       htrans,
    output logic             hwrite,
    output logic [2:0]       hburst,
    output logic [2:0]       hsize,
    output logic [DW-1:0]    hwdata,
    input  logic [DW-1:0]    hrdata,
    input  logic             hready,
    input  logic             hresp,
    output logic [DW-1:0]    rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic             err
);

    localparam int BYTES = DW / 8;
    localparam int SZ    = (DW == 32) ? 2 : (DW == 16) ? 1 : 0;
    localparam int CW    = ((LEN_W > 4) ? LEN_W : 4) + 1;

`ifdef WRAP_BURST_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DRAIN, S_ERR} state_t;

    state_t          state;
    logic [CW-1:0]   beat_idx;
    logic [CW-1:0]   beat_last;
    logic [AW-1:0]   start_addr;
    logic [AW-1:0]   wrap_mask;
    logic            wrap_mode;
    logic [DW-1:0]   seed;
    logic            dp_valid;
    logic            dp_write;

    logic [CW-1:0]   nxt_idx;
    logic [AW-1:0]   nxt_incr;
    logic [AW-1:0]   nxt_addr;
    logic [1:0]      nxt_trans;
    logic [AW-1:0]   cmd_start;

    function automatic logic [CW-1:0] beats_minus1(input logic [2:0] b,
                                                   input logic [LEN_W-1:0] len);
        logic [CW-1:0] r;
        case (b)
            3'd0:       r = '0;
            3'd1:       r = CW'(len);
            3'd2, 3'd3: r = CW'(3);
            3'd4, 3'd5: r = CW'(7);
            default:    r = CW'(15);
        endcase
        return r;
    endfunction

    function automatic logic [AW-1:0] wrap_mask_of(input logic [2:0] b);
        logic [AW-1:0] m;
        case (b)
            3'd2:    m = AW'(4 * BYTES - 1);
            3'd4:    m = AW'(8 * BYTES - 1);
            3'd6:    m = AW'(16 * BYTES - 1);
            default: m = '0;
        endcase
        return m;
    endfunction

    assign hsize     = 3'(SZ);
    assign cmd_start = cmd_addr & ~AW'(BYTES - 1);

    // Wrapping bursts stay inside one aligned block, so only linear bursts
    // can hit a 1KB boundary and need a fresh NONSEQ there.
    always_comb begin
        nxt_idx   = beat_idx + 1'b1;
        nxt_incr  = start_addr + (AW'(nxt_idx) << SZ);
        nxt_addr  = nxt_incr;
        nxt_trans = TR_SEQ;
        if (wrap_mode)
            nxt_addr = (start_addr & ~wrap_mask) | (nxt_incr & wrap_mask);
        if (!wrap_mode && nxt_addr[9:0] == 10'd0)
            nxt_trans = TR_NONSEQ;
    end

    always_ff @(posedge hclk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            haddr      <= '0;
            htrans     <= TR_IDLE;
            hwrite     <= 1'b0;
            hburst     <= 3'd0;
            hwdata     <= '0;
            cmd_ready  <= 1'b1;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            beat_idx   <= '0;
            beat_last  <= '0;
            start_addr <= '0;
            wrap_mask  <= '0;
            wrap_mode  <= 1'b0;
            seed       <= '0;
            dp_valid   <= 1'b0;
            dp_write   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        haddr      <= cmd_start;
                        htrans     <= TR_NONSEQ;
                        hwrite     <= cmd_write;
                        hburst     <= cmd_burst;
                        start_addr <= cmd_start;
                        seed       <= cmd_wdata;
                        beat_idx   <= '0;
                        beat_last  <= beats_minus1(cmd_burst, cmd_len);
                        wrap_mode  <= WRAP_EN && (cmd_burst inside {3'd2, 3'd4, 3'd6});
                        wrap_mask  <= wrap_mask_of(cmd_burst);
                        dp_valid   <= 1'b0;
                        cmd_ready  <= 1'b0;
                        state      <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (dp_valid && hresp) begin
                        htrans   <= TR_IDLE;
                        dp_valid <= 1'b0;
                        if (hready) begin
                            done      <= 1'b1;
                            err       <= 1'b1;
                            cmd_ready <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_ERR;
                        end
                    end else if (hready) begin
                        if (dp_valid && !dp_write) begin
                            rd_data  <= hrdata;
                            rd_valid <= 1'b1;
                        end
                        dp_valid <= 1'b1;
                        dp_write <= hwrite;
                        if (hwrite)
                            hwdata <= seed + DW'(beat_idx);
                        if (beat_idx == beat_last) begin
                            htrans <= TR_IDLE;
                            state  <= S_DRAIN;
                        end else begin
                            beat_idx <= nxt_idx;
                            haddr    <= nxt_addr;
                            htrans   <= nxt_trans;
                        end
                    end
                end
                S_DRAIN: begin
                    if (hresp) begin
                        dp_valid <= 1'b0;
                        if (hready) begin
                            done      <= 1'b1;
                            err       <= 1'b1;
                            cmd_ready <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_ERR;
                        end
                    end else if (hready) begin
                        if (!dp_write) begin
                            rd_data  <= hrdata;
                            rd_valid <= 1'b1;
                        end
                        dp_valid  <= 1'b0;
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_ERR: begin
                    if (hready) begin
                        done      <= 1'b1;
                        err       <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_burst_sequencer.sv
// Bench for ahb_burst_sequencer: a beat-queue model of the burst checked every cycle,
// plus directed scenarios with literal expectations. Honors WRAP_BURST_EN like the design.
module tb_ahb_burst_sequencer;

    localparam int DW = 8;
    localparam int AW = 11;
    localparam int LEN_W = 4;
    localparam int B = DW / 8;

    logic             hclk = 1'b0;
    logic             resetn = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [AW-1:0]    cmd_addr = '0;
    logic [2:0]       cmd_burst = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             cmd_write = 1'b0;
    logic [DW-1:0]    cmd_wdata = '0;
    logic [AW-1:0]    haddr;
    logic [1:0]       htrans;
    logic             hwrite;
    logic [2:0]       hburst;
    logic [2:0]       hsize;
    logic [DW-1:0]    hwdata;
    logic [DW-1:0]    hrdata = '0;
    logic             hready = 1'b1;
    logic             hresp = 1'b0;
    logic [DW-1:0]    rd_data;
    logic             rd_valid;
    logic             done;
    logic             err;

    always #5 hclk = ~hclk;

    ahb_burst_sequencer #(.DW(DW), .AW(AW), .LEN_W(LEN_W)) dut (
        .hclk(hclk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_burst(cmd_burst), .cmd_len(cmd_len), .cmd_write(cmd_write),
        .cmd_wdata(cmd_wdata),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hburst(hburst),
        .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
        .hresp(hresp), .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
        .err(err)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    trans;
        logic          write;
        logic [2:0]    burst;
        logic [DW-1:0] data;
    } beat_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int nbeats(input int bu, input int len);
        case (bu)
            0:       return 1;
            1:       return len + 1;
            2, 3:    return 4;
            4, 5:    return 8;
            default: return 16;
        endcase
    endfunction

    function automatic beat_t beat_of(input int unsigned a, input int bu, input int len,
                                      input bit wr, input int unsigned seed, input int i);
        beat_t b;
        int unsigned start, incr, m;
        bit wrapb;
        start = a & ~(B - 1);
        incr  = (start + i * B) % (1 << AW);
        wrapb = 1'b0;
`ifdef WRAP_BURST_EN
        wrapb = (bu == 2 || bu == 4 || bu == 6);
`endif
        m = nbeats(bu, len) * B - 1;
        b.addr  = AW'(wrapb ? ((start & ~m) | (incr & m)) : incr);
        b.trans = (i == 0 || (!wrapb && incr % 1024 == 0)) ? 2'd2 : 2'd3;
        b.write = wr;
        b.burst = 3'(bu);
        b.data  = DW'(seed + i);
        return b;
    endfunction

    // ---------------- model state ----------------
    beat_t         exp_q[$];
    bit            exp_ready = 1'b1;
    bit            busy = 1'b0, in_err = 1'b0;
    bit            dp_v = 1'b0, dp_w = 1'b0;
    logic [DW-1:0] dp_d = '0;
    bit            exp_rdv = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
    logic [DW-1:0] exp_rd = '0;

    bit            p_acc = 1'b0, p_hready = 1'b0, p_hresp = 1'b0, p_write = 1'b0;
    logic [DW-1:0] p_hrdata = '0, p_seed = '0;
    int            p_addr = 0, p_burst = 0, p_len = 0;

    int            acc_cyc = 0, done_cyc = 0;
    int            dn_cnt = 0, er_cnt = 0, rv_cnt = 0;
    int            seen_a[$];
    int            seen_t[$];

    always @(negedge hclk) begin
        cyc++;
        if (!resetn) begin
            exp_q.delete();
            exp_ready = 1'b1; busy = 1'b0; in_err = 1'b0; dp_v = 1'b0;
            exp_rdv = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
            chk("rst_htrans", 32'(htrans), 0);
            chk("rst_haddr", 32'(haddr), 0);
            chk("rst_hwrite", 32'(hwrite), 0);
            chk("rst_hburst", 32'(hburst), 0);
            chk("rst_hwdata", 32'(hwdata), 0);
            chk("rst_cmd_ready", 32'(cmd_ready), 1);
            chk("rst_rd_data", 32'(rd_data), 0);
            chk("rst_rd_valid", 32'(rd_valid), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_err", 32'(err), 0);
            p_acc = 1'b0;
        end else begin
            // advance the model across the edge that just happened
            exp_rdv = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
            if (p_acc) begin
                for (int i = 0; i < nbeats(p_burst, p_len); i++)
                    exp_q.push_back(beat_of(p_addr, p_burst, p_len, p_write, p_seed, i));
                exp_ready = 1'b0; busy = 1'b1; dp_v = 1'b0; in_err = 1'b0;
            end else if (busy) begin
                if (in_err) begin
                    if (p_hready) begin
                        exp_done = 1'b1; exp_err = 1'b1; exp_ready = 1'b1;
                        busy = 1'b0; in_err = 1'b0;
                    end
                end else if (dp_v && p_hresp) begin
                    exp_q.delete();
                    dp_v = 1'b0;
                    if (p_hready) begin
                        exp_done = 1'b1; exp_err = 1'b1; exp_ready = 1'b1; busy = 1'b0;
                    end else begin
                        in_err = 1'b1;
                    end
                end else if (p_hready) begin
                    if (dp_v && !dp_w) begin
                        exp_rdv = 1'b1;
                        exp_rd  = p_hrdata;
                    end
                    if (exp_q.size() > 0) begin
                        dp_v = 1'b1;
                        dp_w = exp_q[0].write;
                        dp_d = exp_q[0].data;
                        void'(exp_q.pop_front());
                    end else if (dp_v) begin
                        dp_v = 1'b0; exp_done = 1'b1; exp_ready = 1'b1; busy = 1'b0;
                    end
                end
            end

            chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
            if (exp_q.size() > 0) begin
                chk("htrans", 32'(htrans), 32'(exp_q[0].trans));
                chk("haddr", 32'(haddr), 32'(exp_q[0].addr));
                chk("hwrite", 32'(hwrite), 32'(exp_q[0].write));
                chk("hburst", 32'(hburst), 32'(exp_q[0].burst));
            end else begin
                chk("htrans_idle", 32'(htrans), 0);
            end
            if (dp_v && dp_w)
                chk("hwdata", 32'(hwdata), 32'(dp_d));
            chk("rd_valid", 32'(rd_valid), 32'(exp_rdv));
            if (exp_rdv)
                chk("rd_data", 32'(rd_data), 32'(exp_rd));
            chk("done", 32'(done), 32'(exp_done));
            chk("err", 32'(err), 32'(exp_err));
            chk("hsize", 32'(hsize), 0);

            if (done) begin dn_cnt++; done_cyc = cyc; end
            if (err) er_cnt++;
            if (rd_valid) rv_cnt++;
            if (htrans != 2'd0 && hready) begin
                seen_a.push_back(int'(haddr));
                seen_t.push_back(int'(htrans));
            end
            p_acc = cmd_valid && exp_ready;
            if (p_acc) acc_cyc = cyc;
        end
        p_hready = hready;
        p_hresp  = hresp;
        p_hrdata = hrdata;
        p_addr   = int'(cmd_addr);
        p_burst  = int'(cmd_burst);
        p_len    = int'(cmd_len);
        p_write  = cmd_write;
        p_seed   = cmd_wdata;
    end

    initial begin
        forever begin
            @(posedge hclk);
            #1 hrdata = DW'($urandom);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic issue(input int a, input int bu, input int len, input bit wr, input int seed);
        int k = 0;
        while (!cmd_ready && k < 300) begin step(); k++; end
        chk("issue_ready", 32'(cmd_ready), 1);
        seen_a.delete();
        seen_t.delete();
        cmd_addr  = AW'(a);
        cmd_burst = 3'(bu);
        cmd_len   = LEN_W'(len);
        cmd_write = wr;
        cmd_wdata = DW'(seed);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!cmd_ready && k < 300) begin step(); k++; end
        chk("idle_reached", 32'(cmd_ready), 1);
    endtask

    task automatic stall_burst();
        int k = 0;
        while (!cmd_ready && k < 400) begin
            hready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        hready = 1'b1;
        wait_idle();
    endtask

    task automatic chk_seen(input string nm, input int ea[], input int et[]);
        chk({nm, "_count"}, 32'(seen_a.size()), 32'(ea.size()));
        for (int i = 0; i < ea.size() && i < seen_a.size(); i++) begin
            chk({nm, "_addr"}, 32'(seen_a[i]), 32'(ea[i]));
            chk({nm, "_trans"}, 32'(seen_t[i]), 32'(et[i]));
        end
    endtask

    initial begin
        int rv0, dn0, er0, k;
        int a4[], t4[], a1[], t1[], a3[], t3[];
        beat_t pb;

        repeat (2) step();
        resetn = 1'b1;
        step();

        // pin the model against hand-computed beats
        pb = beat_of('h010, 3, 0, 1, 'h40, 3);
        chk("pin_incr4_addr", 32'(pb.addr), 'h13);
        chk("pin_incr4_data", 32'(pb.data), 'h43);
        pb = beat_of('h3FE, 1, 3, 1, 0, 2);
        chk("pin_1kb_addr", 32'(pb.addr), 'h400);
        chk("pin_1kb_trans", 32'(pb.trans), 2);
        pb = beat_of('h00E, 2, 0, 0, 0, 2);
`ifdef WRAP_BURST_EN
        chk("pin_wrap4_addr", 32'(pb.addr), 'h00C);
`else
        chk("pin_wrap4_addr", 32'(pb.addr), 'h010);
`endif

        // 1: write INCR4, zero wait
        issue('h010, 3, 0, 1, 'h40);
        wait_idle();
        step();
        a4 = '{'h10, 'h11, 'h12, 'h13}; t4 = '{2, 3, 3, 3};
        chk_seen("t1", a4, t4);
        chk("t1_done_latency", 32'(done_cyc - acc_cyc), 6);

        // 2: read WRAP4 from 0x00E
        rv0 = rv_cnt;
        issue('h00E, 2, 0, 0, 0);
        wait_idle();
        step();
`ifdef WRAP_BURST_EN
        a4 = '{'h0E, 'h0F, 'h0C, 'h0D};
`else
        a4 = '{'h0E, 'h0F, 'h10, 'h11};
`endif
        chk_seen("t2", a4, t4);
        chk("t2_rd_beats", 32'(rv_cnt - rv0), 4);

        // 3: read SINGLE with a 3-cycle data-phase stall
        rv0 = rv_cnt;
        issue('h005, 0, 0, 0, 0);
        step();
        hready = 1'b0;
        repeat (3) step();
        hready = 1'b1;
        wait_idle();
        step();
        a1 = '{'h05}; t1 = '{2};
        chk_seen("t3", a1, t1);
        chk("t3_rd_beats", 32'(rv_cnt - rv0), 1);
        chk("t3_done_latency", 32'(done_cyc - acc_cyc), 6);

        // 4: INCR len 4 across a 1KB boundary, seed wraps
        issue('h3FE, 1, 3, 1, 'hFE);
        wait_idle();
        step();
        a4 = '{'h3FE, 'h3FF, 'h400, 'h401}; t4 = '{2, 3, 2, 3};
        chk_seen("t4", a4, t4);

        // 5: INCR8 write, ERROR response on beat 2
        dn0 = dn_cnt; er0 = er_cnt;
        issue('h100, 5, 0, 1, 'h10);
        k = 0;
        while (!(htrans != 2'd0 && haddr == AW'('h103)) && k < 50) begin step(); k++; end
        chk("t5_reach_beat3", 32'(haddr), 'h103);
        hresp = 1'b1; hready = 1'b0;
        step();
        hready = 1'b1;
        step();
        hresp = 1'b0;
        wait_idle();
        step();
        a3 = '{'h100, 'h101, 'h102}; t3 = '{2, 3, 3};
        chk_seen("t5", a3, t3);
        chk("t5_done_once", 32'(dn_cnt - dn0), 1);
        chk("t5_err_once", 32'(er_cnt - er0), 1);

        // random stalls: INCR8 read wrapping the address space, WRAP8 write
        issue('h7FC, 5, 0, 0, 0);
        stall_burst();
        issue('h035, 4, 0, 1, 'hA0);
        stall_burst();
        issue('h0F0, 1, 15, 0, 0);
        stall_burst();

        // back-to-back: new command accepted in the done cycle
        issue('h020, 3, 0, 1, 'h01);
        wait_idle();
        issue('h044, 0, 0, 0, 0);
        wait_idle();
        step();

        // 6: reset mid INCR16, then a normal command
        dn0 = dn_cnt;
        issue('h200, 7, 0, 1, 'h55);
        repeat (5) step();
        resetn = 1'b0;
        repeat (2) step();
        resetn = 1'b1;
        step();
        chk("t6_no_done", 32'(dn_cnt - dn0), 0);
        issue('h020, 3, 0, 0, 0);
        wait_idle();
        step();
        a4 = '{'h20, 'h21, 'h22, 'h23}; t4 = '{2, 3, 3, 3};
        chk_seen("t6", a4, t4);
        chk("t6_done_once", 32'(dn_cnt - dn0), 1);

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
